// File: rtl/mod_dds_capture.sv
// ----------------------------------------------------------------------------
// mod_dds_capture
//
// Purpose:
//   Triggered capture buffer for the summed DDS sample stream. A rising edge on
//   ARM_REG arms a capture of LEN_REG samples. The next rising edge of trigger
//   starts storing valid input samples into a 2^N x B block RAM. When the buffer
//   holds LEN samples they are streamed out on an AXI-Stream master port, with
//   tlast marking the final sample.
//
// Ports:
//   aclk, aresetn         clock and asynchronous active-low reset
//   trigger               level trigger from the upstream DDS block
//   s_axis_*              input sample stream (always ready, never stalled)
//   m_axis_*              captured-sample readout stream (tdata/tvalid/tready/tlast)
//   ARM_REG               rising edge arms a capture
//   LEN_REG               samples per capture (clamped to 2^N, 0 = no arm)
//   DECIM_REG             only with CAPTURE_DECIM_EN: keep 1 of every DECIM_REG+1
//   STATUS                0 IDLE, 1 ARMED, 2 CAPTURE, 3 READOUT
//
// Configuration macro:
//   CAPTURE_DECIM_EN      adds DECIM_REG and capture-time decimation
// ----------------------------------------------------------------------------
module mod_dds_capture #(
    parameter int B = 16,
    parameter int N = 10
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         trigger,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic [B-1:0] s_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [B-1:0] m_axis_tdata,
    output logic         m_axis_tlast,
    input  logic         ARM_REG,
    input  logic [N:0]   LEN_REG,
`ifdef CAPTURE_DECIM_EN
    input  logic [7:0]   DECIM_REG,
`endif
    output logic [1:0]   STATUS
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    localparam logic [N:0]   DEPTH    = {1'b1, {N{1'b0}}};
    localparam logic [N:0]   CNT_ONE  = {{N{1'b0}}, 1'b1};
    localparam logic [N-1:0] ADDR_ONE = {{(N-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t         state_q,      state_d;
    logic           arm_dly_q,    arm_dly_d;
    logic           trig_dly_q,   trig_dly_d;
    logic [N:0]     len_q,        len_d;
    logic [N-1:0]   wr_addr_q,    wr_addr_d;   // wraps naturally at LEN = 2^N
    logic [N:0]     wr_num_q,     wr_num_d;    // samples stored so far
    logic [N:0]     rd_num_q,     rd_num_d;    // RAM reads issued so far
    logic           pend_q,       pend_d;      // RAM read in flight
    logic           pend_last_q,  pend_last_d;
    logic           out_valid_q,  out_valid_d;
    logic [B-1:0]   out_data_q,   out_data_d;
    logic           out_last_q,   out_last_d;
    logic           skid_valid_q, skid_valid_d;
    logic [B-1:0]   skid_data_q,  skid_data_d;
    logic           skid_last_q,  skid_last_d;
`ifdef CAPTURE_DECIM_EN
    logic [7:0]     decim_q,      decim_d;
    logic [7:0]     dec_cnt_q,    dec_cnt_d;
`endif

    // ------------------------------------------------------------------------
    // Capture buffer: one write port, one registered read port
    // ------------------------------------------------------------------------
    logic [B-1:0]   mem [0:(1<<N)-1];
    logic [B-1:0]   mem_rd_q;
    logic           wr_en;
    logic           rd_en;
    logic [N-1:0]   rd_addr;

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr_q] <= s_axis_tdata;
        end
        if (rd_en) begin
            mem_rd_q <= mem[rd_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic       arm_rise;
    logic       trig_rise;
    logic       capturing;
    logic       store_sel;
    logic       pop;
    logic [1:0] occ;

    always_comb begin
        state_d      = state_q;
        arm_dly_d    = ARM_REG;
        trig_dly_d   = trigger;
        len_d        = len_q;
        wr_addr_d    = wr_addr_q;
        wr_num_d     = wr_num_q;
        rd_num_d     = rd_num_q;
        pend_d       = 1'b0;
        pend_last_d  = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
`ifdef CAPTURE_DECIM_EN
        decim_d      = decim_q;
        dec_cnt_d    = dec_cnt_q;
`endif

        arm_rise  = ARM_REG & ~arm_dly_q;
        trig_rise = trigger & ~trig_dly_q;

        // The trigger-edge cycle already counts as a capture cycle so that
        // its sample lands at address 0.
        capturing = ((state_q == ST_ARMED) && trig_rise) || (state_q == ST_CAPTURE);

`ifdef CAPTURE_DECIM_EN
        store_sel = (dec_cnt_q == 8'd0);
        if (capturing && s_axis_tvalid) begin
            dec_cnt_d = (dec_cnt_q == decim_q) ? 8'd0 : dec_cnt_q + 8'd1;
        end
`else
        store_sel = 1'b1;
`endif
        wr_en = capturing && s_axis_tvalid && store_sel;

        case (state_q)
            ST_IDLE: begin
                if (arm_rise && (LEN_REG != '0)) begin
                    state_d   = ST_ARMED;
                    len_d     = (LEN_REG > DEPTH) ? DEPTH : LEN_REG;
                    wr_addr_d = '0;
                    wr_num_d  = '0;
                    rd_num_d  = '0;
`ifdef CAPTURE_DECIM_EN
                    decim_d   = DECIM_REG;
                    dec_cnt_d = 8'd0;
`endif
                end
            end
            ST_ARMED: begin
                if (trig_rise) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
            end
            ST_READOUT: begin
                if (out_valid_q && m_axis_tready && out_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Storing the LEN-th sample ends the capture; this also covers LEN = 1
        // where the trigger-cycle sample is the only one.
        if (wr_en) begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
            wr_num_d  = wr_num_q + CNT_ONE;
            if ((wr_num_q + CNT_ONE) == len_q) begin
                state_d = ST_READOUT;
            end
        end

        // Readout: output register + skid register give two slots; a read is
        // only issued when the data it returns is guaranteed a free slot.
        pop     = out_valid_q & m_axis_tready;
        occ     = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q};
        rd_addr = rd_num_q[N-1:0];
        rd_en   = (state_q == ST_READOUT) && (rd_num_q < len_q) &&
                  ((occ - {1'b0, pop}) < 2'd2);
        if (rd_en) begin
            rd_num_d    = rd_num_q + CNT_ONE;
            pend_d      = 1'b1;
            pend_last_d = ((rd_num_q + CNT_ONE) == len_q);
        end

        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = pend_q;
                skid_data_d  = mem_rd_q;
                skid_last_d  = pend_last_q;
            end else if (pend_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = mem_rd_q;
                out_last_d   = pend_last_q;
            end else begin
                out_valid_d  = 1'b0;
                out_last_d   = 1'b0;
            end
        end else if (pend_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = mem_rd_q;
            skid_last_d  = pend_last_q;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            arm_dly_q    <= 1'b0;
            trig_dly_q   <= 1'b0;
            len_q        <= '0;
            wr_addr_q    <= '0;
            wr_num_q     <= '0;
            rd_num_q     <= '0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
`ifdef CAPTURE_DECIM_EN
            decim_q      <= 8'd0;
            dec_cnt_q    <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            arm_dly_q    <= arm_dly_d;
            trig_dly_q   <= trig_dly_d;
            len_q        <= len_d;
            wr_addr_q    <= wr_addr_d;
            wr_num_q     <= wr_num_d;
            rd_num_q     <= rd_num_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
`ifdef CAPTURE_DECIM_EN
            decim_q      <= decim_d;
            dec_cnt_q    <= dec_cnt_d;
`endif
        end
    end

    assign s_axis_tready = 1'b1;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign STATUS        = state_q;

endmodule

// File: tb/tb_mod_dds_capture.sv
// ----------------------------------------------------------------------------
// tb_mod_dds_capture
//
// Self-checking bench for mod_dds_capture. Expected samples are pushed to a
// scoreboard queue as capture stimulus is driven and popped as readout beats
// are accepted. One task per scenario; a summary line closes the run.
// ----------------------------------------------------------------------------
module tb_mod_dds_capture;

    localparam int B = 16;
    localparam int N = 10;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         trigger;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [B-1:0] s_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [B-1:0] m_axis_tdata;
    logic         m_axis_tlast;
    logic         ARM_REG;
    logic [N:0]   LEN_REG;
`ifdef CAPTURE_DECIM_EN
    logic [7:0]   DECIM_REG;
`endif
    logic [1:0]   STATUS;

    mod_dds_capture #(.B(B), .N(N)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .trigger       (trigger),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .ARM_REG       (ARM_REG),
        .LEN_REG       (LEN_REG),
`ifdef CAPTURE_DECIM_EN
        .DECIM_REG     (DECIM_REG),
`endif
        .STATUS        (STATUS)
    );

    always #5 aclk = ~aclk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [B-1:0] sb[$];      // expected readout samples
    logic [B-1:0] obs_d[$];   // accepted beats: data
    logic         obs_l[$];   // accepted beats: tlast
    int           stab_err;
    bit           timed_out;
    logic [B-1:0] exp_d;
    logic         exp_l;
    int           n_exp;

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic do_arm(input int len);
        LEN_REG = (N+1)'(len);
        ARM_REG = 1'b1;
        tick();
        ARM_REG = 1'b0;
        tick();
    endtask

    // Drive n ramp samples with trigger rising on the first one.
    task automatic capture(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = B'(base + k);
            trigger       = 1'b1;
            tick();
        end
        s_axis_tvalid = 1'b0;
        trigger       = 1'b0;
        tick();
    endtask

    // Accept readout beats with tready following pat (bit = cycle mod 4).
    // Stops after a tlast beat, after max_beats beats, or when the budget runs out.
    task automatic drain(input int budget, input logic [3:0] pat, input int max_beats);
        bit           pv = 1'b0;
        bit           pr = 1'b0;
        logic [B-1:0] pd = '0;
        logic         pl = 1'b0;
        obs_d.delete();
        obs_l.delete();
        stab_err  = 0;
        timed_out = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge aclk);
            if (pv && !pr && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== pl))
                stab_err++;
            m_axis_tready = pat[c % 4];
            pv = m_axis_tvalid;
            pr = m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                obs_d.push_back(m_axis_tdata);
                obs_l.push_back(m_axis_tlast);
                if (m_axis_tlast === 1'b1 || obs_d.size() >= max_beats) return;
            end
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #1;
        total_cnt++; if (STATUS !== 2'd0) $display("FAIL reset_status: got %0d want 0", STATUS); else pass_cnt++;
        total_cnt++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); else pass_cnt++;
        total_cnt++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); else pass_cnt++;
        total_cnt++; if (m_axis_tdata !== '0) $display("FAIL reset_tdata: got %0d want 0", m_axis_tdata); else pass_cnt++;
        tick(); tick();
        aresetn = 1'b1;
        tick();
        total_cnt++; if (s_axis_tready !== 1'b1) $display("FAIL reset_tready: got %b want 1", s_axis_tready); else pass_cnt++;
        $display("reset: released");
    endtask

    task automatic test_basic();
        do_arm(8);
        total_cnt++; if (STATUS !== 2'd1) $display("FAIL basic_armed: got %0d want 1", STATUS); else pass_cnt++;
        for (int k = 0; k < 8; k++) sb.push_back(B'(100 + k));
        capture(100, 11);
        total_cnt++; if (STATUS !== 2'd3) $display("FAIL basic_readout_state: got %0d want 3", STATUS); else pass_cnt++;
        drain(100, 4'b1111, 100000);
        tick();
        m_axis_tready = 1'b0;
        n_exp = sb.size();
        total_cnt++; if (obs_d.size() !== n_exp) $display("FAIL basic_beats: got %0d want %0d", obs_d.size(), n_exp); else pass_cnt++;
        for (int i = 0; i < obs_d.size() && sb.size() > 0; i++) begin
            exp_d = sb.pop_front(); exp_l = (sb.size() == 0);
            total_cnt++;
            if (obs_d[i] !== exp_d || obs_l[i] !== exp_l)
                $display("FAIL basic_beat%0d: got data=%0d last=%b want data=%0d last=%b", i, obs_d[i], obs_l[i], exp_d, exp_l);
            else pass_cnt++;
        end
        sb.delete();
        total_cnt++; if (STATUS !== 2'd0) $display("FAIL basic_idle: got %0d want 0", STATUS); else pass_cnt++;
        $display("basic: len=8 beats=%0d", obs_d.size());
    endtask

    task automatic test_stall();
        do_arm(4);
        for (int k = 0; k < 4; k++) sb.push_back(B'(200 + k));
        capture(200, 4);
        drain(100, 4'b1001, 100000);
        tick();
        m_axis_tready = 1'b0;
        total_cnt++; if (stab_err !== 0) $display("FAIL stall_stable: got %0d changes want 0", stab_err); else pass_cnt++;
        n_exp = sb.size();
        total_cnt++; if (obs_d.size() !== n_exp) $display("FAIL stall_beats: got %0d want %0d", obs_d.size(), n_exp); else pass_cnt++;
        for (int i = 0; i < obs_d.size() && sb.size() > 0; i++) begin
            exp_d = sb.pop_front(); exp_l = (sb.size() == 0);
            total_cnt++;
            if (obs_d[i] !== exp_d || obs_l[i] !== exp_l)
                $display("FAIL stall_beat%0d: got data=%0d last=%b want data=%0d last=%b", i, obs_d[i], obs_l[i], exp_d, exp_l);
            else pass_cnt++;
        end
        sb.delete();
        total_cnt++; if (STATUS !== 2'd0) $display("FAIL stall_idle: got %0d want 0", STATUS); else pass_cnt++;
        $display("stall: len=4 beats=%0d", obs_d.size());
    endtask

    task automatic test_trigger_rules();
        // Edge while IDLE, trigger then held high through the arm.
        trigger = 1'b1;
        tick(); tick();
        total_cnt++; if (STATUS !== 2'd0) $display("FAIL trig_idle_edge: got %0d want 0", STATUS); else pass_cnt++;
        do_arm(4);
        total_cnt++; if (STATUS !== 2'd1) $display("FAIL trig_armed: got %0d want 1", STATUS); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = B'(900 + k);
            tick();
        end
        s_axis_tvalid = 1'b0;
        total_cnt++; if (STATUS !== 2'd1) $display("FAIL trig_level_no_capture: got %0d want 1", STATUS); else pass_cnt++;
        trigger = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) sb.push_back(B'(300 + k));
        // Re-trigger and an arm edge during CAPTURE must both be ignored.
        for (int k = 0; k < 6; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = B'(300 + k);
            trigger       = (k != 1);
            ARM_REG       = (k == 1);
            tick();
        end
        s_axis_tvalid = 1'b0;
        trigger       = 1'b0;
        ARM_REG       = 1'b0;
        tick();
        total_cnt++; if (STATUS !== 2'd3) $display("FAIL trig_readout_state: got %0d want 3", STATUS); else pass_cnt++;
        drain(100, 4'b1111, 100000);
        tick();
        m_axis_tready = 1'b0;
        n_exp = sb.size();
        total_cnt++; if (obs_d.size() !== n_exp) $display("FAIL trig_beats: got %0d want %0d", obs_d.size(), n_exp); else pass_cnt++;
        for (int i = 0; i < obs_d.size() && sb.size() > 0; i++) begin
            exp_d = sb.pop_front(); exp_l = (sb.size() == 0);
            total_cnt++;
            if (obs_d[i] !== exp_d || obs_l[i] !== exp_l)
                $display("FAIL trig_beat%0d: got data=%0d last=%b want data=%0d last=%b", i, obs_d[i], obs_l[i], exp_d, exp_l);
            else pass_cnt++;
        end
        sb.delete();
        total_cnt++; if (STATUS !== 2'd0) $display("FAIL trig_idle: got %0d want 0", STATUS); else pass_cnt++;
        $display("trigger_rules: len=4 beats=%0d", obs_d.size());
    endtask

    task automatic test_full_len();
        int lens[2];
        lens[0] = 1024;
        lens[1] = 2000;
        for (int t = 0; t < 2; t++) begin
            do_arm(lens[t]);
            total_cnt++; if (STATUS !== 2'd1) $display("FAIL full%0d_armed: got %0d want 1", lens[t], STATUS); else pass_cnt++;
            for (int k = 0; k < 1024; k++) sb.push_back(B'(1000 + 7000 * t + k));
            capture(1000 + 7000 * t, 1030);
            drain(3000, 4'b1111, 100000);
            tick();
            m_axis_tready = 1'b0;
            n_exp = sb.size();
            total_cnt++; if (obs_d.size() !== n_exp) $display("FAIL full%0d_beats: got %0d want %0d", lens[t], obs_d.size(), n_exp); else pass_cnt++;
            for (int i = 0; i < obs_d.size() && sb.size() > 0; i++) begin
                exp_d = sb.pop_front(); exp_l = (sb.size() == 0);
                total_cnt++;
                if (obs_d[i] !== exp_d || obs_l[i] !== exp_l)
                    $display("FAIL full%0d_beat%0d: got data=%0d last=%b want data=%0d last=%b", lens[t], i, obs_d[i], obs_l[i], exp_d, exp_l);
                else pass_cnt++;
            end
            sb.delete();
            total_cnt++; if (STATUS !== 2'd0) $display("FAIL full%0d_idle: got %0d want 0", lens[t], STATUS); else pass_cnt++;
            $display("full_len: LEN_REG=%0d beats=%0d", lens[t], obs_d.size());
        end
        do_arm(0);
        tick();
        total_cnt++; if (STATUS !== 2'd0) $display("FAIL len0_stays_idle: got %0d want 0", STATUS); else pass_cnt++;
        $display("full_len: LEN_REG=0 status=%0d", STATUS);
    endtask

    task automatic test_reset_mid_readout();
        do_arm(8);
        for (int k = 0; k < 8; k++) sb.push_back(B'(500 + k));
        capture(500, 8);
        drain(100, 4'b1111, 3);
        tick();
        total_cnt++; if (obs_d.size() !== 3) $display("FAIL midrst_pre_beats: got %0d want 3", obs_d.size()); else pass_cnt++;
        for (int i = 0; i < obs_d.size() && i < 3; i++) begin
            exp_d = sb.pop_front();
            total_cnt++;
            if (obs_d[i] !== exp_d || obs_l[i] !== 1'b0)
                $display("FAIL midrst_beat%0d: got data=%0d last=%b want data=%0d last=0", i, obs_d[i], obs_l[i], exp_d);
            else pass_cnt++;
        end
        sb.delete();
        m_axis_tready = 1'b0;
        aresetn = 1'b0;
        #1;
        total_cnt++; if (m_axis_tvalid !== 1'b0) $display("FAIL midrst_tvalid: got %b want 0", m_axis_tvalid); else pass_cnt++;
        total_cnt++; if (STATUS !== 2'd0) $display("FAIL midrst_status: got %0d want 0", STATUS); else pass_cnt++;
        tick();
        aresetn = 1'b1;
        tick(); tick(); tick();
        total_cnt++; if (m_axis_tvalid !== 1'b0) $display("FAIL midrst_no_readout: got %b want 0", m_axis_tvalid); else pass_cnt++;
        do_arm(4);
        for (int k = 0; k < 4; k++) sb.push_back(B'(600 + k));
        capture(600, 4);
        drain(100, 4'b1111, 100000);
        tick();
        m_axis_tready = 1'b0;
        n_exp = sb.size();
        total_cnt++; if (obs_d.size() !== n_exp) $display("FAIL midrst_fresh_beats: got %0d want %0d", obs_d.size(), n_exp); else pass_cnt++;
        for (int i = 0; i < obs_d.size() && sb.size() > 0; i++) begin
            exp_d = sb.pop_front(); exp_l = (sb.size() == 0);
            total_cnt++;
            if (obs_d[i] !== exp_d || obs_l[i] !== exp_l)
                $display("FAIL midrst_fresh_beat%0d: got data=%0d last=%b want data=%0d last=%b", i, obs_d[i], obs_l[i], exp_d, exp_l);
            else pass_cnt++;
        end
        sb.delete();
        total_cnt++; if (STATUS !== 2'd0) $display("FAIL midrst_fresh_idle: got %0d want 0", STATUS); else pass_cnt++;
        $display("reset_mid_readout: fresh beats=%0d", obs_d.size());
    endtask

`ifdef CAPTURE_DECIM_EN
    task automatic test_decim();
        DECIM_REG = 8'd2;
        do_arm(4);
        DECIM_REG = 8'd0;
        for (int k = 0; k < 4; k++) sb.push_back(B'(3 * k));
        capture(0, 12);
        drain(100, 4'b1111, 100000);
        tick();
        m_axis_tready = 1'b0;
        n_exp = sb.size();
        total_cnt++; if (obs_d.size() !== n_exp) $display("FAIL decim_beats: got %0d want %0d", obs_d.size(), n_exp); else pass_cnt++;
        for (int i = 0; i < obs_d.size() && sb.size() > 0; i++) begin
            exp_d = sb.pop_front(); exp_l = (sb.size() == 0);
            total_cnt++;
            if (obs_d[i] !== exp_d || obs_l[i] !== exp_l)
                $display("FAIL decim_beat%0d: got data=%0d last=%b want data=%0d last=%b", i, obs_d[i], obs_l[i], exp_d, exp_l);
            else pass_cnt++;
        end
        sb.delete();
        $display("decim: DECIM_REG=2 beats=%0d", obs_d.size());
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        trigger       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        ARM_REG       = 1'b0;
        LEN_REG       = '0;
`ifdef CAPTURE_DECIM_EN
        DECIM_REG     = 8'd0;
`endif
        test_reset();
        test_basic();
        test_stall();
        test_trigger_rules();
        test_full_len();
        test_reset_mid_readout();
`ifdef CAPTURE_DECIM_EN
        test_decim();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mod_dds_capture.md
MOD_DDS_CAPTURE -- requirements
Module: mod_dds_capture

Interface
REQ-001 Parameter: B, 16, sample width (matches DDS summed output).
REQ-002 Parameter: N, 10, log2 of capture buffer depth (1024 samples).
REQ-003 Port: aclk  in  1  single clock for all logic.
REQ-004 Port: aresetn  in  1  asynchronous active-low reset.
REQ-005 Port: trigger  in  1  level trigger from upstream DDS block's trigger_out.
REQ-006 Port: s_axis_tvalid  in  1, s_axis_tready  out  1, s_axis_tdata  in  B  summed DDS sample stream.
REQ-007 Port: m_axis_tvalid  out  1, m_axis_tready  in  1, m_axis_tdata  out  B, m_axis_tlast  out  1  captured-sample readout stream.
REQ-008 Port: ARM_REG  in  1  rising edge arms a capture.
REQ-009 Port: LEN_REG  in  N+1  samples per capture.
REQ-010 Port: STATUS  out  2  FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 READOUT.

Function
REQ-011 s_axis_tready SHALL be 1 in every state after reset; input is never back-pressured; samples outside CAPTURE are discarded.
REQ-012 Edge detection: ARM_REG and trigger each registered once; rising edge = current 1, registered 0.
REQ-013 IDLE -> ARMED on ARM_REG rising edge if LEN_REG != 0; LEN_REG == 0 keeps IDLE.
REQ-014 LEN_REG latched on the IDLE->ARMED transition; values > 2^N clamp to 2^N; later changes ignored until next arm.
REQ-015 ARMED -> CAPTURE on trigger rising edge; sample with s_axis_tvalid=1 in that same cycle is stored at address 0.
REQ-016 CAPTURE: each cycle with s_axis_tvalid=1 writes s_axis_tdata at write counter, counter +1; cycles with tvalid=0 store nothing.
REQ-017 CAPTURE -> READOUT in the cycle after the LEN-th sample is written.
REQ-018 READOUT: samples 0..LEN-1 output in order; m_axis_tvalid asserted no later than 2 cycles after entering READOUT.
REQ-019 AXIS rules: m_axis_tdata/tlast held stable while tvalid=1 and tready=0; with tready held 1, one sample per cycle, no bubbles after the first.
REQ-020 m_axis_tlast=1 only with sample LEN-1.
REQ-021 READOUT -> IDLE in the cycle after the tlast beat is accepted (tvalid & tready).
REQ-022 ARM_REG edges in ARMED/CAPTURE/READOUT ignored; trigger edges outside ARMED ignored, including re-triggers during CAPTURE.
REQ-023 Buffer: single-port-write, single-port-read RAM, 1-cycle read latency, 2^N x B; output skid register required for REQ-019.
REQ-024 LEN = 2^N: write counter wraps to 0 after the last write; no overwrite of sample 0 occurs.

Reset
REQ-025 On aresetn=0 (any time, including mid-CAPTURE or mid-READOUT): STATUS=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, counters=0, edge registers=0; s_axis_tready=1 after release.
REQ-026 Buffer contents undefined after reset; no readout occurs without a new arm/trigger.

Configuration
REQ-027 Macro CAPTURE_DECIM_EN: when defined, adds port DECIM_REG  in  8  (latched with LEN_REG); in CAPTURE stores one of every DECIM_REG+1 valid samples, starting with the trigger-cycle sample; DECIM_REG=0 equals no decimation.
REQ-028 Without CAPTURE_DECIM_EN: no DECIM_REG port; every valid sample in CAPTURE is stored.

Verification
REQ-029 LEN_REG=8, arm, trigger edge with ramp data 100,101,...: readout 100..107, tlast on 107, STATUS back to 0.
REQ-030 LEN_REG=4, m_axis_tready toggled 1,0,0,1 per cycle: each sample held stable while stalled, exactly 4 beats, tlast on 4th.
REQ-031 Trigger edge in IDLE, then arm, then trigger high constant: no capture until a new rising edge; second trigger edge mid-CAPTURE has no effect.
REQ-032 LEN_REG=1024 and LEN_REG=2000: 1024 samples each, tlast on 1024th; LEN_REG=0 arm keeps STATUS=0.
REQ-033 aresetn pulsed low mid-READOUT after 3 beats: m_axis_tvalid=0 immediately, STATUS=0; subsequent arm/trigger captures fresh data correctly.
REQ-034 With CAPTURE_DECIM_EN, DECIM_REG=2, LEN_REG=4, ramp 0,1,2,...: readout 0,3,6,9.
